// File: rtl/framebuffer_ctrl.sv
// framebuffer_ctrl: paces the drawing engine's pixel stream into a double-buffered
// frame RAM and serves VGA pixel reads from the buffer on screen. RAM access is
// time-sliced: a read slot and a write slot alternate on every Clk.
module framebuffer_ctrl #(
    parameter int         X_MIN     = 80,
    parameter int         Y_MIN     = 0,
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 240,
    parameter int         BUF_WORDS = 38400,
    parameter logic [7:0] BG_COLOR  = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [7:0]  draw_color,
    input  logic        draw_done,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        wr_en,
    output logic        buffer_using,
    output logic [7:0]  pixel_color,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic {
        READ_SLOT  = 1'b0,
        WRITE_SLOT = 1'b1
    } phase_t;

    localparam logic [16:0] BUF1_BASE = 17'(BUF_WORDS);

    // A coordinate left of / above the window wraps modulo 1024 to a large
    // offset, so one unsigned compare per axis covers both window edges
    // (valid while the window ends inside the 10-bit screen space).
    function automatic logic in_window(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] dx;
        logic [9:0] dy;
        dx = x - 10'(X_MIN);
        dy = y - 10'(Y_MIN);
        return (dx < 10'(WIDTH)) && (dy < 10'(HEIGHT));
    endfunction

    // Row-major window offset, 17-bit unsigned with a constant WIDTH multiply.
    function automatic logic [16:0] win_offset(input logic [9:0] x, input logic [9:0] y);
        return (17'(y) - 17'(Y_MIN)) * 17'(WIDTH) + (17'(x) - 17'(X_MIN));
    endfunction

    phase_t      phase;
    phase_t      phase_next;
    logic [2:0]  fsync;       // [1:0] synchroniser, [2] previous synchronised level
    logic        frame_rise;
    logic        swap_req;
    logic        rd_flag;     // in-window flag of the read address just issued
    logic        rd_flag_d;   // same flag, aligned with mem_rdata
    logic        wr_in;
    logic [16:0] wr_addr;
    logic        rd_in;
    logic [16:0] rd_addr;

    // Slot phase register.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (Reset) phase <= READ_SLOT;
        else       phase <= phase_next;
    end

    // Next slot: read and write slots simply alternate.
    always_comb begin
        // NOTE: default assigned first so no path through the block leaves the
        // output unassigned, which would infer a latch.
        phase_next = READ_SLOT;
        case (phase)
            READ_SLOT:  phase_next = WRITE_SLOT;
            WRITE_SLOT: phase_next = READ_SLOT;
            default:    phase_next = READ_SLOT;
        endcase
    end

    assign wr_en      = (phase == WRITE_SLOT) && !draw_done;
    assign frame_rise = fsync[1] & ~fsync[2];

    // Address generation for both slots; out-of-window reads clamp to the buffer base.
    always_comb begin
        wr_in   = in_window(draw_x, draw_y);
        wr_addr = (buffer_using ? 17'd0 : BUF1_BASE) + win_offset(draw_x, draw_y);
        rd_in   = in_window(DrawX, DrawY);
        rd_addr = (buffer_using ? BUF1_BASE : 17'd0)
                + (rd_in ? win_offset(DrawX, DrawY) : 17'd0);
    end

    // Frame strobe synchroniser, edge detect and buffer swap; a frame edge while
    // the engine is still drawing is dropped, not queued.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync        <= 3'b000;
            swap_req     <= 1'b0;
            buffer_using <= 1'b0;
        end else begin
            fsync    <= {fsync[1:0], frame_clk};
            swap_req <= frame_rise & draw_done;
            if (swap_req) buffer_using <= ~buffer_using;
        end
    end

    // RAM port: write slot registers the engine pixel, read slot the VGA address.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_addr  <= 17'd0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
        end else if (phase == WRITE_SLOT) begin
            mem_addr  <= wr_addr;
            mem_wdata <= draw_color;
            mem_we    <= wr_en & wr_in;
        end else begin
            mem_addr  <= rd_addr;
            mem_we    <= 1'b0;
        end
    end

    // Read pipeline: flag follows the address into the RAM; data lands in
    // pixel_color at the end of the following read slot, 2 Clk after sampling.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_flag     <= 1'b0;
            rd_flag_d   <= 1'b0;
            pixel_color <= BG_COLOR;
        end else if (phase == WRITE_SLOT) begin
            rd_flag_d   <= rd_flag;
        end else begin
            rd_flag     <= rd_in;
            pixel_color <= rd_flag_d ? mem_rdata : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Testbench for framebuffer_ctrl: directed checks with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_framebuffer_ctrl;

    localparam int         X_MIN     = 80;
    localparam int         Y_MIN     = 0;
    localparam int         WIDTH     = 160;
    localparam int         HEIGHT    = 240;
    localparam int         BUF_WORDS = 38400;
    localparam logic [7:0] BG        = 8'h00;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  draw_x, draw_y, DrawX, DrawY;
    logic [7:0]  draw_color;
    logic        draw_done;
    logic        wr_en, buffer_using, mem_we;
    logic [7:0]  pixel_color, mem_wdata, mem_rdata;
    logic [16:0] mem_addr;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    framebuffer_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color), .draw_done(draw_done),
        .DrawX(DrawX), .DrawY(DrawY),
        .wr_en(wr_en), .buffer_using(buffer_using), .pixel_color(pixel_color),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM stand-in: content is a fixed hash of the address, or a
    // forced constant for directed read tests.
    logic       rd_force;
    logic [7:0] rd_force_val;

    function automatic logic [7:0] ram_fn(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endfunction

    always @(posedge Clk) mem_rdata <= rd_force ? rd_force_val : ram_fn(mem_addr);

    // ---------------- behavioural model ----------------
    int m_ph, m_bu, m_addr, m_wdata, m_we, m_pix, m_rflag, m_rdexp;
    int f1, f2, f3, f4, d1;   // frame_clk / draw_done as seen on previous edges

    function automatic int inwin(input int x, input int y);
        return (x >= X_MIN && x < X_MIN + WIDTH && y >= Y_MIN && y < Y_MIN + HEIGHT) ? 1 : 0;
    endfunction

    function automatic int woff(input int x, input int y);
        return (y - Y_MIN) * WIDTH + (x - X_MIN);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_bu = 0; m_addr = 0; m_wdata = 0; m_we = 0;
        m_pix = BG; m_rflag = 0; m_rdexp = BG;
        f1 = 0; f2 = 0; f3 = 0; f4 = 0; d1 = 0;
    endtask

    // Advance the model across the coming Clk edge using the inputs now applied.
    task automatic model_step();
        int tog;
        int old_bu;
        tog    = (f3 == 1 && f4 == 0 && d1 == 1) ? 1 : 0;
        old_bu = m_bu;
        if (m_ph == 1) begin
            m_rdexp = m_rflag ? int'(rd_force ? rd_force_val : ram_fn(17'(m_addr))) : int'(BG);
            m_addr  = ((old_bu ? 0 : BUF_WORDS) + woff(int'(draw_x), int'(draw_y))) & 'h1FFFF;
            m_wdata = int'(draw_color);
            m_we    = (!draw_done && inwin(int'(draw_x), int'(draw_y)) == 1) ? 1 : 0;
        end else begin
            m_pix   = m_rdexp;
            m_rflag = inwin(int'(DrawX), int'(DrawY));
            m_addr  = (old_bu ? BUF_WORDS : 0) + (m_rflag ? woff(int'(DrawX), int'(DrawY)) : 0);
            m_we    = 0;
        end
        if (tog == 1) m_bu = 1 - m_bu;
        m_ph = 1 - m_ph;
        f4 = f3; f3 = f2; f2 = f1; f1 = int'(frame_clk); d1 = int'(draw_done);
    endtask

    // Compare process: every negedge, outputs against the model.
    always @(negedge Clk) begin
        if (Reset) begin
            model_reset();
            check("rst_wr_en", 32'(wr_en), 0);
            check("rst_buffer_using", 32'(buffer_using), 0);
            check("rst_pixel_color", 32'(pixel_color), 32'(BG));
            check("rst_mem_addr", 32'(mem_addr), 0);
            check("rst_mem_wdata", 32'(mem_wdata), 0);
            check("rst_mem_we", 32'(mem_we), 0);
        end else begin
            check("cyc_wr_en", 32'(wr_en), (m_ph == 1 && !draw_done) ? 1 : 0);
            check("cyc_buffer_using", 32'(buffer_using), m_bu);
            check("cyc_mem_addr", 32'(mem_addr), m_addr);
            check("cyc_mem_wdata", 32'(mem_wdata), m_wdata);
            check("cyc_mem_we", 32'(mem_we), m_we);
            check("cyc_pixel_color", 32'(pixel_color), m_pix);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (m_ph != p && n < 4);
        if (m_ph != p) begin
            tests++; fails++;
            $display("FAIL wait_phase: phase %0d not reached, last %0d", p, m_ph);
        end
    endtask

    function automatic logic [9:0] pick_coord(input int lo, input int span);
        int r;
        r = int'($urandom_range(0, 3));
        case (r)
            0:       return 10'($urandom_range(lo, lo + span - 1));
            1:       return 10'($urandom_range(0, 1023));
            2:       return 10'(lo - 1 + int'($urandom_range(0, 1)));
            default: return 10'(lo + span - 1 + int'($urandom_range(0, 1)));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1; frame_clk = 1'b0; draw_done = 1'b0;
        draw_x = '0; draw_y = '0; draw_color = '0; DrawX = '0; DrawY = '0;
        rd_force = 1'b0; rd_force_val = 8'h00;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        // Idle after reset: wr_en alternates starting with the read slot.
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk); #1;
            check("idle_wr_en", 32'(wr_en), k % 2);
            check("idle_buffer_using", 32'(buffer_using), 0);
            check("idle_pixel_color", 32'(pixel_color), 32'h00);
        end

        // In-window write into buffer 1 while buffer 0 is displayed.
        wait_phase(1);
        draw_x = 10'd100; draw_y = 10'd5; draw_color = 8'h0C;
        @(negedge Clk); #1;
        check("wr_slot_wr_en", 32'(wr_en), 1);
        @(posedge Clk); #1;
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", 32'(mem_addr), 39220);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h0C);

        // Marker pixel outside the window: consumed, not written.
        wait_phase(1);
        draw_x = 10'd10; draw_y = 10'd10; draw_color = 8'h30;
        @(negedge Clk); #1;
        check("marker_wr_en", 32'(wr_en), 1);
        @(posedge Clk); #1;
        check("marker_mem_we", 32'(mem_we), 0);

        // Frame edge with the engine done: swap within 4 Clk.
        draw_done = 1'b1; frame_clk = 1'b1;
        n = 0;
        while (buffer_using !== 1'b1 && n < 8) begin
            @(posedge Clk); #1;
            n++;
            if (n == 2) frame_clk = 1'b0;
        end
        frame_clk = 1'b0;
        check("swap_done", 32'(buffer_using), 1);
        check("swap_within_4clk", (n <= 4) ? 1 : 0, 1);

        // Frame edge while still drawing: dropped frame.
        draw_done = 1'b0;
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (6) @(posedge Clk);
        #1 check("dropped_frame", 32'(buffer_using), 1);

        // Read from buffer 1, then an out-of-window read.
        draw_done = 1'b1; rd_force = 1'b1; rd_force_val = 8'h2C;
        wait_phase(0);
        DrawX = 10'd80; DrawY = 10'd1;
        @(posedge Clk); #1;
        check("rd_mem_addr", 32'(mem_addr), 38560);
        @(posedge Clk); #1;
        DrawX = 10'd20;
        @(posedge Clk); #1;
        check("rd_pixel_color", 32'(pixel_color), 32'h2C);
        check("rd_clamped_addr", 32'(mem_addr), 38400);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("rd_outside_bg", 32'(pixel_color), 32'(BG));
        rd_force = 1'b0;

        // Asynchronous reset in the middle of a write slot.
        draw_done = 1'b0;
        wait_phase(1);
        check("pre_reset_wr_en", 32'(wr_en), 1);
        #1 Reset = 1'b1;
        #1;
        check("async_mem_we", 32'(mem_we), 0);
        check("async_wr_en", 32'(wr_en), 0);
        check("async_buffer_using", 32'(buffer_using), 0);
        check("async_mem_addr", 32'(mem_addr), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk); #1;
        check("post_reset_read_slot", 32'(wr_en), 0);

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge Clk); #1;
            Reset      = ($urandom_range(0, 499) == 0);
            draw_x     = pick_coord(X_MIN, WIDTH);
            draw_y     = pick_coord(Y_MIN, HEIGHT);
            draw_color = 8'($urandom_range(0, 255));
            DrawX      = pick_coord(X_MIN, WIDTH);
            DrawY      = pick_coord(Y_MIN, HEIGHT);
            if ($urandom_range(0, 5) == 0) draw_done = ~draw_done;
            if ($urandom_range(0, 7) == 0) frame_clk = ~frame_clk;
        end
        @(posedge Clk); #1 Reset = 1'b0;

        @(negedge Clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/framebuffer_ctrl.md
Name: framebuffer_ctrl

Overview:
- Sits directly downstream of drawing_engine and consumes its pixel stream (draw_x, draw_y, draw_color).
- Paces that stream with wr_en and owns the double-buffered on-chip frame RAM (two buffers, one byte per pixel).
- Tells the drawing engine which buffer is on screen (buffer_using) and serves VGA pixel reads from that buffer.
- Memory access is time-sliced: one read slot and one write slot alternate on every Clk.

Parameters:
- X_MIN, 80, left edge of the game window in screen pixels
- Y_MIN, 0, top edge of the game window
- WIDTH, 160, window width in pixels
- HEIGHT, 240, window height in pixels
- BUF_WORDS, 38400, words per buffer (WIDTH*HEIGHT); buffer 1 base = BUF_WORDS
- BG_COLOR, 8'h00, colour returned for reads outside the window

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  VGA vsync-rate frame strobe, asynchronous to nothing but unsynchronised; rising edge = frame boundary
- draw_x  in  10  pixel x from drawing engine
- draw_y  in  10  pixel y from drawing engine
- draw_color  in  8  pixel colour from drawing engine
- draw_done  in  1  high while drawing engine has finished its frame
- DrawX  in  10  VGA scan x
- DrawY  in  10  VGA scan y
- wr_en  out  1  write-slot strobe; drawing engine advances one pixel per cycle it is high
- buffer_using  out  1  index of buffer being displayed; engine draws into !buffer_using
- pixel_color  out  8  colour for VGA at (DrawX, DrawY), 2-Clk latency
- mem_addr  out  17  registered RAM address
- mem_wdata  out  8  registered RAM write data
- mem_we  out  1  registered RAM write enable
- mem_rdata  in  8  synchronous RAM read data, valid 1 Clk after mem_addr is presented

Behaviour:
- Reset values: phase=0, wr_en=0, buffer_using=0, pixel_color=BG_COLOR, mem_addr=0, mem_wdata=0, mem_we=0. Reset clears the frame_clk synchroniser, the swap request and the read pipeline.
- phase toggles every Clk after reset: 0 = read slot, 1 = write slot.
- wr_en = phase & ~draw_done. It is combinational from registered state and is 0 during reset.
- Write slot: at the edge ending a phase=1 cycle, register mem_wdata=draw_color and mem_addr = wbase + (draw_y-Y_MIN)*WIDTH + (draw_x-X_MIN), where wbase = buffer_using ? 0 : BUF_WORDS.
  - mem_we=1 only if wr_en was high and X_MIN<=draw_x<X_MIN+WIDTH and Y_MIN<=draw_y<Y_MIN+HEIGHT.
  - Out-of-window pixels (e.g. the buffer-state marker at x=10/11) are consumed but dropped; mem_we=0.
- Read slot: at the edge ending a phase=0 cycle, register mem_addr = rbase + window offset of (DrawX, DrawY), with rbase = buffer_using ? BUF_WORDS : 0, and mem_we=0.
  - Also register an in-window flag. Out-of-window reads still drive an address, clamped to rbase.
- Read pipeline: RAM samples the read address at the next edge. mem_rdata is captured into pixel_color at the following edge (the end of the next phase=0 cycle).
  - Latency from DrawX/DrawY sample to pixel_color update is 2 Clk.
  - If the delayed in-window flag is 0, pixel_color=BG_COLOR.
  - pixel_color holds between updates.
- Address arithmetic: all offsets are computed in 17 bits unsigned; the multiply is a constant WIDTH multiply.
- Swap:
  - frame_clk passes through a 2-FF synchroniser plus edge detect.
  - On a detected rising edge with draw_done=1, buffer_using toggles on the next Clk.
  - On a rising edge with draw_done=0, no swap occurs and the old buffer stays displayed (dropped frame). No request is queued.
- Simultaneous swap and write slot: the write uses the buffer_using value before the toggle.
- Reset mid-frame returns all state to the reset values immediately (asynchronous). The first write slot after deassertion is the second cycle.

Test Plan:
- Reset, then 4 Clk idle with draw_done=0: wr_en pattern 0,1,0,1; buffer_using=0; pixel_color=8'h00.
- buffer_using=0, draw=(100,5,8'h0C) during a write slot: next cycle mem_we=1, mem_addr=39220, mem_wdata=8'h0C.
- Write slot with draw=(10,10,8'h30): mem_we=0, and wr_en was still high.
- draw_done=1, then pulse frame_clk: buffer_using goes to 1 within 4 Clk. With draw_done=0, a pulse leaves buffer_using unchanged.
- buffer_using=1, DrawX=80, DrawY=1 sampled in read slot: mem_addr=38560. mem_rdata=8'h2C returned next cycle gives pixel_color=8'h2C 2 Clk after sampling. DrawX=20 gives BG_COLOR.
- Assert Reset asynchronously mid-write-slot: mem_we, wr_en and phase are 0 before the next edge; buffer_using=0.
